// File: rtl/mux_arbiter.sv
`default_nettype none
//============================================================================
// Module      : mux_arbiter
// Description : Four-requester round-robin arbiter that drives the select of
//               a shared 4:1 mux. Grants are registered and one-hot. An owner
//               keeps the grant until it drops its request.
//               Optional macro MUX_ARB_BURST_LIMIT_EN adds a burst limit:
//               after BURST_MAX cycles the grant rotates if others wait.
// Revision    : 1.0 - initial release
//============================================================================
module mux_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       Output
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    logic [0:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic [1:0] r_ptr;
    logic       r_busy;

    logic [1:0] w_next;
    logic       w_found;
    logic [1:0] w_idx;
    logic       w_mux;

    // Reject out-of-range burst limits at elaboration time
    if (BURST_MAX < 2 || BURST_MAX > 16) begin : g_burst_max_check
        $error("mux_arbiter: BURST_MAX must be in 2..16");
    end

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int c_CNT_W = $clog2(BURST_MAX + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_others;
    logic               w_burst_done;

    // Other requesters waiting, and whether the owner used its full burst
    always_comb begin
        w_others     = |(req & ~r_gnt);
        w_burst_done = (r_cnt == c_CNT_W'(BURST_MAX - 1));
    end
`endif

    // Round-robin search: first requester after the last owner, owner last
    always_comb begin
        w_next  = r_ptr;
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Grant state machine with registered grant, select and pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd3;
`ifdef MUX_ARB_BURST_LIMIT_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_found) begin
                        r_state <= c_ST_GRANT;
                        r_gnt   <= 4'b0001 << w_next;
                        r_busy  <= 1'b1;
                        r_sel   <= w_next;
                        r_ptr   <= w_next;
`ifdef MUX_ARB_BURST_LIMIT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                default: begin
                    if (!req[r_sel]) begin
                        // Owner released: hand over directly, or go idle
                        if (w_found) begin
                            r_gnt  <= 4'b0001 << w_next;
                            r_sel  <= w_next;
                            r_ptr  <= w_next;
`ifdef MUX_ARB_BURST_LIMIT_EN
                            r_cnt  <= '0;
`endif
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_gnt   <= 4'b0000;
                            r_busy  <= 1'b0;
                        end
                    end
`ifdef MUX_ARB_BURST_LIMIT_EN
                    else if (w_burst_done && w_others) begin
                        // Burst exhausted with others waiting: rotate
                        r_gnt <= 4'b0001 << w_next;
                        r_sel <= w_next;
                        r_ptr <= w_next;
                        r_cnt <= '0;
                    end else if (!w_burst_done) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    // Shared mux, forced low while no one owns it
    always_comb begin
        case (r_sel)
            2'd0:    w_mux = I0;
            2'd1:    w_mux = I1;
            2'd2:    w_mux = I2;
            default: w_mux = I3;
        endcase
    end

    assign gnt    = r_gnt;
    assign s1     = r_sel[1];
    assign s0     = r_sel[0];
    assign busy   = r_busy;
    assign Output = r_busy & w_mux;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_mux_arbiter
// Description : Directed self-checking bench for mux_arbiter: reset, initial
//               priority, hand-over without idle, idle hold of select,
//               round-robin pointer, reset mid-grant and grant holding
//               (burst rotation when MUX_ARB_BURST_LIMIT_EN is defined).
// Revision    : 1.0 - initial release
//============================================================================
module tb_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       I0, I1, I2, I3;
    logic [3:0] gnt;
    logic       s1, s0, busy, Output;

    int checks;
    int errors;

    mux_arbiter #(.BURST_MAX(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .I0     (I0),
        .I1     (I1),
        .I2     (I2),
        .I3     (I3),
        .gnt    (gnt),
        .s1     (s1),
        .s0     (s0),
        .busy   (busy),
        .Output (Output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b0000;
        I0 = 1'b1; I1 = 1'b1; I2 = 1'b1; I3 = 1'b1;
        step(); step();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || {s1, s0} !== 2'b00 || Output !== 1'b0) begin
            errors++;
            $display("FAIL reset gnt=%b busy=%b sel=%b out=%b required 0000 0 00 0",
                     gnt, busy, {s1, s0}, Output);
        end
        rst = 1'b0;
    endtask

    // All four request together, each drops after its grant: 0,1,2,3,0
    task automatic test_rotation();
        logic [3:0] reqs [5];
        logic [3:0] exp_g [5];
        logic [1:0] exp_s [5];
        reqs  = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 5; k++) begin
            req = reqs[k];
            step();
            checks++;
            if (gnt !== exp_g[k] || {s1, s0} !== exp_s[k] || busy !== 1'b1) begin
                errors++;
                $display("FAIL rotation[%0d] gnt=%b sel=%b busy=%b required %b %b 1",
                         k, gnt, {s1, s0}, busy, exp_g[k], exp_s[k]);
            end
        end
    endtask

    // Output follows the selected input with no latency while busy
    task automatic test_output_path();
        logic [3:0] pat;
        // owner is requester 0 here
        for (int k = 0; k < 4; k++) begin
            pat = 4'b0001 << k;
            {I3, I2, I1, I0} = pat;
            #1;
            checks++;
            if (Output !== pat[0]) begin
                errors++;
                $display("FAIL out_path[%0d] out=%b required %b", k, Output, pat[0]);
            end
        end
    endtask

    // Release: gnt clears, select holds; lone requester 2 then release
    task automatic test_idle_hold();
        req = 4'b0000;
        step();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after0 gnt=%b busy=%b sel=%b required 0000 0 00",
                     gnt, busy, {s1, s0});
        end
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100 || busy !== 1'b1 || {s1, s0} !== 2'b10) begin
            errors++;
            $display("FAIL single2 gnt=%b busy=%b sel=%b required 0100 1 10",
                     gnt, busy, {s1, s0});
        end
        req = 4'b0000;
        {I3, I2, I1, I0} = 4'b1111;
        step();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || {s1, s0} !== 2'b10 || Output !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold2 gnt=%b busy=%b sel=%b out=%b required 0000 0 10 0",
                     gnt, busy, {s1, s0}, Output);
        end
    endtask

    // Pointer stays at 2 through idle: next search order is 3,0,1,2
    task automatic test_pointer_after_idle();
        req = 4'b1011;
        step();
        checks++;
        if (gnt !== 4'b1000 || {s1, s0} !== 2'b11) begin
            errors++;
            $display("FAIL ptr_after_idle gnt=%b sel=%b required 1000 11", gnt, {s1, s0});
        end
        req = 4'b0000;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ptr_idle busy=%b required 0", busy);
        end
    endtask

    // Reset in the middle of a grant drops the owner at once
    task automatic test_reset_mid_grant();
        req = 4'b1000;
        step();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL mid_pre gnt=%b required 1000", gnt);
        end
        rst = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0000 || {s1, s0} !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst gnt=%b sel=%b busy=%b required 0000 00 0",
                     gnt, {s1, s0}, busy);
        end
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b1000 || {s1, s0} !== 2'b11) begin
            errors++;
            $display("FAIL mid_post gnt=%b sel=%b required 1000 11", gnt, {s1, s0});
        end
    endtask

`ifdef MUX_ARB_BURST_LIMIT_EN
    // Burst of 4: 0001 x4, 0010 x4, repeating; lone requester holds forever
    task automatic test_hold();
        logic [3:0] exp;
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0;
        req = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            step();
            exp = (((k / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
            checks++;
            if (gnt !== exp) begin
                errors++;
                $display("FAIL burst[%0d] gnt=%b required %b", k, gnt, exp);
            end
        end
        req = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (gnt !== 4'b0001) begin
                errors++;
                $display("FAIL burst_single[%0d] gnt=%b required 0001", k, gnt);
            end
        end
    endtask
`else
    // Owner 0 holds for 100 cycles despite requester 1 waiting
    task automatic test_hold();
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0;
        req = 4'b0011;
        for (int k = 0; k < 100; k++) begin
            step();
            checks++;
            if (gnt !== 4'b0001 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d] gnt=%b busy=%b required 0001 1", k, gnt, busy);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; req = 4'b0000;
        I0 = 1'b0; I1 = 1'b0; I2 = 1'b0; I3 = 1'b0;
        test_reset();
        test_rotation();
        test_output_path();
        test_idle_hold();
        test_pointer_after_idle();
        test_reset_mid_grant();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
